// File: rtl/mdu_pkg.sv
// Shared M-extension constants: funct7/funct3 decode values and MDU state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Imported by the decoder, the ACU and mdu_sequencer so all of them decode the same encodings.
package mdu_pkg;

  // funct7 that steers an R-type op to the MDU instead of the ALU
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  // funct3 encodings of the RV32M ops
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: multiply add-and-shift-right, or restoring divide shift-left-and-subtract.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_o.
// Ports: div_mode_i selects divide, acc_i is {hi,lo} (mul) or {rem,quot} (div),
//        operand_i is the multiplicand or divisor magnitude, acc_o is the next accumulator.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: the multiplier sits in the low half and is consumed LSB first;
    // the add carry is kept so the shift brings it into the top bit.
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    mul_next = {mul_sum, acc_i[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the partial remainder, then
    // try the subtract; a clear borrow bit means the divisor fitted.
    div_shift = acc_i[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, operand_i};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end

    acc_o = div_mode_i ? div_next : mul_next;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit beside the ALU in EX, one radix-2 step per clock.
// Latency: Done WIDTH+2 cycles after an accepted start; 2 cycles for divide-by-zero / overflow.
// Backpressure: starts are only accepted in IDLE; the pipeline must hold EX while Busy is high.
// Ports: clock/async active-low reset, Start/Kill/funct3/operands in;
//        Busy (CALC/FIX), Done (one-cycle pulse) and the held Result out.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             MDU_CLOCK_50,
  input  logic             MDU_RESET_InLow,
  input  logic             MDU_Start_In,
  input  logic             MDU_Kill_In,
  input  logic [2:0]       MDU_Funt3_InBUS,
  input  logic [WIDTH-1:0] MDU_OperandA_InBUS,
  input  logic [WIDTH-1:0] MDU_OperandB_InBUS,
  output logic             MDU_Busy_Out,
  output logic             MDU_Done_Out,
  output logic [WIDTH-1:0] MDU_Result_OutBUS
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         f3_q, f3_d;
  logic               negp_q, negp_d;     // negate product / quotient
  logic               negr_q, negr_d;     // negate remainder (follows dividend)
  logic               special_q, special_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               a_neg, b_neg, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_res;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (f3_q[2]),
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .acc_o      (step_acc)
  );

  // Operand magnitudes from the request; MUL low word is sign-agnostic so it stays unsigned.
  always_comb begin
    is_div = MDU_Funt3_InBUS[2];
    a_neg  = MDU_OperandA_InBUS[WIDTH-1] &
             ((MDU_Funt3_InBUS == F3_MULH) || (MDU_Funt3_InBUS == F3_MULHSU) ||
              (MDU_Funt3_InBUS == F3_DIV)  || (MDU_Funt3_InBUS == F3_REM));
    b_neg  = MDU_OperandB_InBUS[WIDTH-1] &
             ((MDU_Funt3_InBUS == F3_MULH) || (MDU_Funt3_InBUS == F3_DIV) ||
              (MDU_Funt3_InBUS == F3_REM));
    a_mag  = a_neg ? -MDU_OperandA_InBUS : MDU_OperandA_InBUS;
    b_mag  = b_neg ? -MDU_OperandB_InBUS : MDU_OperandB_InBUS;
  end

  // Sign correction and word selection applied in FIX.
  always_comb begin
    prod_fix = negp_q ? -acc_q : acc_q;
    quot_fix = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (special_q) begin
      fix_res = acc_q[WIDTH-1:0];          // precomputed at acceptance
    end else if (f3_q[2]) begin
      fix_res = f3_q[1] ? rem_fix : quot_fix;
    end else if (f3_q == F3_MUL) begin
      fix_res = prod_fix[WIDTH-1:0];
    end else begin
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    negp_d    = negp_q;
    negr_d    = negr_q;
    special_d = special_q;
    result_d  = result_q;

    if (MDU_Kill_In) begin
      state_d = MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (MDU_Start_In) begin
            f3_d      = MDU_Funt3_InBUS;
            negp_d    = a_neg ^ b_neg;
            negr_d    = a_neg;
            cnt_d     = CW'(WIDTH - 1);
            special_d = 1'b0;
            if (is_div) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
            // Divide corner cases: result is known now, so skip the iterations.
            if (is_div && (MDU_OperandB_InBUS == '0)) begin
              special_d = 1'b1;
              acc_d     = {{WIDTH{1'b0}},
                           MDU_Funt3_InBUS[1] ? MDU_OperandA_InBUS : {WIDTH{1'b1}}};
            end else if (is_div && !MDU_Funt3_InBUS[0] &&
                         (MDU_OperandA_InBUS == MIN_NEG) &&
                         (MDU_OperandB_InBUS == {WIDTH{1'b1}})) begin
              special_d = 1'b1;
              acc_d     = {{WIDTH{1'b0}},
                           MDU_Funt3_InBUS[1] ? {WIDTH{1'b0}} : MDU_OperandA_InBUS};
            end
            state_d = special_d ? MDU_FIX : MDU_CALC;
          end
        end
        MDU_CALC: begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            state_d = MDU_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        MDU_FIX: begin
          result_d = fix_res;
          state_d  = MDU_DONE;
        end
        MDU_DONE: begin
          state_d = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge MDU_CLOCK_50 or negedge MDU_RESET_InLow) begin
    if (!MDU_RESET_InLow) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      negp_q    <= 1'b0;
      negr_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      negp_q    <= negp_d;
      negr_q    <= negr_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign MDU_Busy_Out      = (state_q == MDU_CALC) || (state_q == MDU_FIX);
  assign MDU_Done_Out      = (state_q == MDU_DONE);
  assign MDU_Result_OutBUS = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed results, Done latency and Busy window per op,
// plus ignored restart, Kill abort, Kill-with-Start rejection and mid-op reset.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  f3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.WIDTH(32)) dut (
    .MDU_CLOCK_50       (clk),
    .MDU_RESET_InLow    (rst_n),
    .MDU_Start_In       (start),
    .MDU_Kill_In        (kill),
    .MDU_Funt3_InBUS    (f3),
    .MDU_OperandA_InBUS (op_a),
    .MDU_OperandB_InBUS (op_b),
    .MDU_Busy_Out       (busy),
    .MDU_Done_Out       (done),
    .MDU_Result_OutBUS  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle (that negedge is cycle 0). Checks Done latency,
  // the Busy window, the result and that Done drops again. poke_n>0 re-asserts Start with
  // other operands in that cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int poke_n);
    int lat      = -1;
    int busy_err = 0;
    f3 = fn; op_a = a; op_b = b; start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h1234_5678;
        f3   = 3'b101;
      end
      if (n == poke_n) begin
        start = 1'b1;
        op_a  = 32'd99;
        op_b  = 32'd3;
      end
      if (busy !== (n < exp_lat)) busy_err++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_busy"}, busy_err, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; f3 = '0; op_a = '0; op_b = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Main ops, full-length iterations
    run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34, 0);

    // Short-circuit divide cases
    run_op("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 0);
    run_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         2, 0);
    run_op("divov",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_op("remov",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 0);

    // Start re-asserted mid-CALC with other operands is ignored
    run_op("restart", 3'b000, 32'd3, 32'd5, 32'd15, 34, 5);

    // Kill at cycle 10 of a DIVU: idle at 11, no Done, result held (15)
    saw_done = 0;
    f3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) saw_done = 1;
      if (n == 10) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done | saw_done[0]}, 32'd0);
    chk("kill_res", result, 32'd15);
    // New start accepted in cycle 11
    run_op("postkill", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);

    // Kill together with Start in IDLE rejects the start
    f3 = 3'b000; op_a = 32'd2; op_b = 32'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("killstart_idle", {31'd0, busy | done}, 32'd0);

    // Reset at cycle 20 of a DIV clears everything immediately
    f3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul34", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
